// File: rtl/pll_rst_pkg.sv
// rtl/pll_rst_pkg.sv - shared state encoding and defaults for the PLL reset sequencer
package pll_rst_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } pll_state_t;

    localparam int DEF_SYNC_STAGES        = 2;
    localparam int DEF_LOCK_STABLE_CYCLES = 1024;
    localparam int DEF_RESET_HOLD_CYCLES  = 16;
    localparam int DEF_LOSS_CNT_W         = 8;

    // One counter serves both STABLE and HOLD, so it is sized for the longer phase.
    function automatic int cnt_width(input int stable_cycles, input int hold_cycles);
        return $clog2(((stable_cycles > hold_cycles) ? stable_cycles : hold_cycles) + 1);
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// rtl/pll_reset_sequencer_if.sv - lock input and reset/status outputs of the sequencer
interface pll_reset_sequencer_if #(
    parameter int LOSS_CNT_W = 8
);
    logic                  locked;
    logic                  reset_out_n;
    logic                  ready;
    logic [LOSS_CNT_W-1:0] lock_loss_count;
    logic [1:0]            state_dbg;

    modport master (
        input  locked,
        output reset_out_n,
        output ready,
        output lock_loss_count,
        output state_dbg
    );

    modport slave (
        output locked,
        input  reset_out_n,
        input  ready,
        input  lock_loss_count,
        input  state_dbg
    );
endinterface

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - N-stage single-bit synchroniser with async active-low clear
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];
endmodule

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - qualifies PLL lock and releases a synchronous reset
module pll_reset_sequencer
    import pll_rst_pkg::*;
#(
    parameter int SYNC_STAGES        = DEF_SYNC_STAGES,
    parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
    parameter int RESET_HOLD_CYCLES  = DEF_RESET_HOLD_CYCLES,
    parameter int LOSS_CNT_W         = DEF_LOSS_CNT_W
) (
    input  logic                   clock_in,
    input  logic                   reset_n,
    pll_reset_sequencer_if.master  bus
);
    localparam int CNT_W = cnt_width(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);

    logic                  lock_s;
    pll_state_t            state;
    logic [CNT_W-1:0]      cnt;
    logic                  reset_out_q;
    logic                  ready_q;
    logic [LOSS_CNT_W-1:0] loss_cnt;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clock_in),
        .rst_n (reset_n),
        .d     (bus.locked),
        .q     (lock_s)
    );

    // Any lock_s drop before RUN restarts qualification without counting as a loss.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state       <= WAIT_LOCK;
            cnt         <= '0;
            reset_out_q <= 1'b0;
            ready_q     <= 1'b0;
            loss_cnt    <= '0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    cnt         <= '0;
                    reset_out_q <= 1'b0;
                    ready_q     <= 1'b0;
                    if (lock_s) state <= STABLE;
                end
                STABLE: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state <= HOLD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == HOLD_LAST) begin
                        state       <= RUN;
                        cnt         <= '0;
                        reset_out_q <= 1'b1;
                        ready_q     <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state       <= WAIT_LOCK;
                        reset_out_q <= 1'b0;
                        ready_q     <= 1'b0;
                        if (loss_cnt != '1) loss_cnt <= loss_cnt + 1'b1;
                    end
                end
                default: begin
                    state       <= WAIT_LOCK;
                    cnt         <= '0;
                    reset_out_q <= 1'b0;
                    ready_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.reset_out_n     = reset_out_q;
    assign bus.ready           = ready_q;
    assign bus.lock_loss_count = loss_cnt;
    assign bus.state_dbg       = state;
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - directed self-checking bench for pll_reset_sequencer
module tb_pll_reset_sequencer;
    logic clk;
    logic reset_n;
    int   checks;
    int   errors;
    int   exp_loss;

    pll_reset_sequencer_if #(.LOSS_CNT_W(8)) bus ();

    pll_reset_sequencer #(
        .SYNC_STAGES        (2),
        .LOCK_STABLE_CYCLES (8),
        .RESET_HOLD_CYCLES  (4),
        .LOSS_CNT_W         (8)
    ) dut (
        .clock_in (clk),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int rst_o, input int rdy, input int st);
        chk({tag, "_reset_out_n"}, 32'(bus.reset_out_n), rst_o);
        chk({tag, "_ready"},       32'(bus.ready), rdy);
        chk({tag, "_state"},       32'(bus.state_dbg), st);
        chk({tag, "_count"},       32'(bus.lock_loss_count), exp_loss);
    endtask

    // Drops lock from RUN and relocks, leaving the sequencer in RUN again.
    task automatic loss_cycle();
        bus.locked = 1'b0;
        step(3);
        exp_loss = (exp_loss < 255) ? exp_loss + 1 : 255;
        bus.locked = 1'b1;
        step(15);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        exp_loss   = 0;
        reset_n    = 1'b0;
        bus.locked = 1'b1;

        // Power-up with lock already present
        step(5);
        chk_out("por", 0, 0, 0);
        reset_n = 1'b1;
        step(3);
        chk_out("por_e3", 0, 0, 1);
        step(8);
        chk_out("por_e11", 0, 0, 2);
        step(3);
        chk_out("por_e14", 0, 0, 2);
        step(1);
        chk_out("por_e15", 1, 1, 3);
        step(5);
        chk_out("por_e20", 1, 1, 3);

        // Lock loss in RUN, then relock
        bus.locked = 1'b0;
        step(2);
        chk_out("loss_k2", 1, 1, 3);
        step(1);
        exp_loss = 1;
        chk_out("loss_k3", 0, 0, 0);
        bus.locked = 1'b1;
        step(14);
        chk_out("relock_e14", 0, 0, 2);
        step(1);
        chk_out("relock_e15", 1, 1, 3);

        // Glitch during STABLE: drop at counter 5 for 3 cycles
        bus.locked = 1'b0;
        step(3);
        exp_loss = 2;
        chk_out("g1_loss", 0, 0, 0);
        bus.locked = 1'b1;
        step(8);
        chk_out("g1_stable", 0, 0, 1);
        bus.locked = 1'b0;
        step(3);
        chk_out("g1_abort", 0, 0, 0);
        bus.locked = 1'b1;
        step(14);
        chk_out("g1_e14", 0, 0, 2);
        step(1);
        chk_out("g1_e15", 1, 1, 3);

        // Glitch during HOLD: lock_s low when the hold counter reads 2
        bus.locked = 1'b0;
        step(3);
        exp_loss = 3;
        chk_out("g2_loss", 0, 0, 0);
        bus.locked = 1'b1;
        step(11);
        chk_out("g2_hold", 0, 0, 2);
        bus.locked = 1'b0;
        step(2);
        bus.locked = 1'b1;
        step(1);
        chk_out("g2_abort", 0, 0, 0);
        step(1);
        chk_out("g2_no_early", 0, 0, 0);
        step(12);
        chk_out("g2_e14", 0, 0, 2);
        step(1);
        chk_out("g2_e15", 1, 1, 3);

        // Saturation of the loss counter
        for (int i = 0; i < 260; i++) loss_cycle();
        chk_out("sat_260", 1, 1, 3);
        chk("sat_255", 32'(bus.lock_loss_count), 255);
        loss_cycle();
        chk("sat_hold", 32'(bus.lock_loss_count), 255);

        // Asynchronous reset in RUN, observed before the next clock edge
        #2;
        reset_n = 1'b0;
        #1;
        exp_loss = 0;
        chk_out("async_now", 0, 0, 0);
        step(3);
        chk_out("async_held", 0, 0, 0);
        reset_n = 1'b1;
        step(14);
        chk_out("async_e14", 0, 0, 2);
        step(1);
        chk_out("async_e15", 1, 1, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
